mem_responder: RTL and testbench

//  Memory-side responder for the multi-cycle core's memory interface. Accepts

---
 rtl/mem_responder.sv | 157 +++++++++++++++
 tb/tb_mem_responder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-organised RAM responder with WAIT_CYCLES wait states and a one-cycle mem_ready pulse.
// Optional MEM_ERR_EN flags misaligned accesses on mem_err instead of force-aligning them.
module mem_responder #(
    parameter int    ADDR_W      = 10,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_funct3,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err,
    output logic [1:0]  dbg_state
);
    // Handshake: the requester holds mem_op until it sees mem_ready; inputs are only sampled in IDLE.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wr_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [2:0]          f3_q;
    logic [31:0]         rdata_q, rdata_d;
    logic [31:0]         mem_q [0:(1<<ADDR_W)-1];

    logic                accept;
    logic                cur_wr, cur_bad, bad_q;
    logic [ADDR_W+1:0]   cur_addr;
    logic [2:0]          cur_f3;
    logic [31:0]         rd_word, rd_ext;
    logic [1:0]          rd_off, wr_off;
    logic [7:0]          rd_byte;
    logic [15:0]         rd_half;
    logic [3:0]          wr_be;
    logic [31:0]         wr_data;
    logic                do_write;
    logic                unused_addr_hi;

    function automatic logic [1:0] lane_off(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   lane_off = a;
            2'b01:   lane_off = {a[1], 1'b0};
            default: lane_off = 2'b00;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = a[0];
            default: misaligned = |a;
        endcase
    endfunction

    assign unused_addr_hi = ^mem_addr[31:ADDR_W+2];
    assign accept = (state_q == S_IDLE) && (mem_op == 2'b01 || mem_op == 2'b10);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states RESP follows IDLE directly, so the read path looks at the live request there.
    always_comb begin
        cur_wr   = (state_q == S_IDLE) ? (mem_op == 2'b10) : wr_q;
        cur_addr = (state_q == S_IDLE) ? mem_addr[ADDR_W+1:0] : addr_q;
        cur_f3   = (state_q == S_IDLE) ? mem_funct3 : f3_q;
        rd_word  = mem_q[cur_addr[ADDR_W+1:2]];
        rd_off   = lane_off(cur_f3, cur_addr[1:0]);
        rd_byte  = rd_word[{rd_off, 3'b000} +: 8];
        rd_half  = rd_word[{rd_off[1], 4'b0000} +: 16];
        case (cur_f3[1:0])
            2'b00:   rd_ext = {{24{~cur_f3[2] & rd_byte[7]}}, rd_byte};
            2'b01:   rd_ext = {{16{~cur_f3[2] & rd_half[15]}}, rd_half};
            default: rd_ext = rd_word;
        endcase
`ifdef MEM_ERR_EN
        cur_bad = misaligned(cur_f3, cur_addr[1:0]);
        bad_q   = misaligned(f3_q, addr_q[1:0]);
`else
        cur_bad = 1'b0;
        bad_q   = 1'b0;
`endif
        rdata_d = (cur_wr || cur_bad) ? 32'h0 : rd_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_d == S_RESP && state_q != S_RESP) rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= (mem_op == 2'b10);
            addr_q  <= mem_addr[ADDR_W+1:0];
            wdata_q <= mem_wdata;
            f3_q    <= mem_funct3;
        end
    end

    always_comb begin
        wr_off = lane_off(f3_q, addr_q[1:0]);
        case (f3_q[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << wr_off;
                wr_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wr_be   = 4'b0011 << wr_off;
                wr_data = {2{wdata_q[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = wdata_q;
            end
        endcase
        do_write = (state_q == S_RESP) && wr_q && !rst && !bad_q;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (do_write && wr_be[i]) mem_q[addr_q[ADDR_W+1:2]][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

    // A reset arriving in RESP cancels the pulse along with the write.
    assign mem_ready = (state_q == S_RESP) && !rst;
    assign mem_err   = mem_ready && bad_q;
    assign mem_rdata = rdata_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance checked against a byte-array RAM model.
module tb_mem_responder;
  localparam int AW = 6;
`ifdef MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [1:0]  a_op, b_op;
  logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
  logic [2:0]  a_f3, b_f3;
  logic [31:0] a_rdata, b_rdata;
  logic        a_ready, b_ready, a_err, b_err;
  logic [1:0]  a_state, b_state;

  mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(2), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .mem_op(a_op), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .mem_funct3(a_f3), .mem_rdata(a_rdata), .mem_ready(a_ready), .mem_err(a_err),
    .dbg_state(a_state));

  mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0), .INIT_FILE("")) dut0 (
    .clk(clk), .rst(rst), .mem_op(b_op), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .mem_funct3(b_f3), .mem_rdata(b_rdata), .mem_ready(b_ready), .mem_err(b_err),
    .dbg_state(b_state));

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0]  ref_a [256];
  logic [7:0]  ref_b [256];
  logic [31:0] exp_q [$];

  // reference model: little-endian byte array, size-aligned access, 256-byte wrap
  function automatic logic misal(input logic [31:0] addr, input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1'b0;
    if (f3[1:0] == 2'b01) return addr[0];
    return addr[1:0] != 2'b00;
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_read(input int sel, input logic [31:0] addr, input logic [2:0] f3);
    int n, a;
    logic [31:0] v;
    if (ERR_EN && misal(addr, f3)) return 32'h0;
    n = nbytes(f3);
    a = int'(addr & 32'hFF);
    a = a - (a % n);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(sel == 1 ? ref_b[a+i] : ref_a[a+i]) << (8*i));
    if (n < 4 && !f3[2] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic model_write(input int sel, input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3);
    int n, a;
    if (ERR_EN && misal(addr, f3)) return;
    n = nbytes(f3);
    a = int'(addr & 32'hFF);
    a = a - (a % n);
    for (int i = 0; i < n; i++) begin
      if (sel == 1) ref_b[a+i] = wd[8*i +: 8];
      else          ref_a[a+i] = wd[8*i +: 8];
    end
  endtask

  // driver tasks
  task automatic drive(input int sel, input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3);
    if (sel == 1) begin b_op = op; b_addr = addr; b_wdata = wd; b_f3 = f3; end
    else          begin a_op = op; a_addr = addr; a_wdata = wd; a_f3 = f3; end
  endtask

  task automatic do_req(input int sel, input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] f3,
                        output logic [31:0] rd, output logic er, output int lat);
    lat = 0; rd = '0; er = 1'b0;
    @(negedge clk);
    drive(sel, op, addr, wd, f3);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if ((sel == 1) ? b_ready : a_ready) begin
        lat = n;
        rd  = (sel == 1) ? b_rdata : a_rdata;
        er  = (sel == 1) ? b_err : a_err;
        break;
      end
    end
    drive(sel, 2'b00, addr, wd, f3);
  endtask

  // one request through the scoreboard: expected data queued, checked on completion
  task automatic txn(input string name, input int sel, input logic [1:0] op, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [2:0] f3);
    logic [31:0] rd, exp;
    logic er, exp_er;
    int lat, exp_lat;
    exp_er  = ERR_EN && misal(addr, f3);
    exp_lat = (sel == 1) ? 1 : 3;
    if (op == 2'b01) exp_q.push_back(model_read(sel, addr, f3));
    else begin
      exp_q.push_back(32'h0);
      model_write(sel, addr, wd, f3);
    end
    do_req(sel, op, addr, wd, f3, rd, er, lat);
    exp = exp_q.pop_front();
    n_checks++;
    if (lat !== exp_lat) begin
      n_errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (rd !== exp) begin
      n_errors++;
      $display("FAIL %s rdata: got %h expected %h (addr %h f3 %0d)", name, rd, exp, addr, f3);
    end
    n_checks++;
    if (er !== exp_er) begin
      n_errors++;
      $display("FAIL %s mem_err: got %b expected %b", name, er, exp_er);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ready: got %b/%b expected 0/0", a_ready, b_ready);
    end
    n_checks++;
    if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_rdata: got %h/%h expected 0", a_rdata, b_rdata);
    end
    n_checks++;
    if (a_err !== 1'b0 || b_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_err: got %b/%b expected 0", a_err, b_err);
    end
    n_checks++;
    if (a_state !== 2'd0 || b_state !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_state: got %0d/%0d expected 0 (IDLE)", a_state, b_state);
    end
  endtask

  task automatic test_fill();
    for (int w = 0; w < 64; w++) txn("fill_a", 0, 2'b10, 32'(w*4), $urandom, 3'b010);
    for (int w = 0; w < 16; w++) txn("fill_b", 1, 2'b10, 32'(w*4), $urandom, 3'b010);
  endtask

  task automatic test_sized();
    txn("sw_10", 0, 2'b10, 32'h10, 32'hDEAD_BEEF, 3'b010);
    txn("lw_10", 0, 2'b01, 32'h10, 32'h0, 3'b010);
    txn("sb_13", 0, 2'b10, 32'h13, 32'h0000_0080, 3'b000);
    txn("lb_13", 0, 2'b01, 32'h13, 32'h0, 3'b000);
    txn("lbu_13", 0, 2'b01, 32'h13, 32'h0, 3'b100);
    txn("lw_10b", 0, 2'b01, 32'h10, 32'h0, 3'b010);
    txn("sh_22", 0, 2'b10, 32'h22, 32'h0000_8001, 3'b001);
    txn("lh_22", 0, 2'b01, 32'h22, 32'h0, 3'b001);
    txn("lhu_22", 0, 2'b01, 32'h22, 32'h0, 3'b101);
    txn("alias_sw", 0, 2'b10, 32'hABCD_0110, 32'hCAFE_F00D, 3'b010);
    txn("alias_lw", 0, 2'b01, 32'h10, 32'h0, 3'b010);
  endtask

  task automatic test_misalign();
    txn("sw_41", 0, 2'b10, 32'h41, 32'h1234_5678, 3'b010);
    txn("lw_40", 0, 2'b01, 32'h40, 32'h0, 3'b010);
    txn("lw_43", 0, 2'b01, 32'h43, 32'h0, 3'b010);
    txn("lh_23", 0, 2'b01, 32'h23, 32'h0, 3'b001);
  endtask

  task automatic test_reset_mid();
    logic seen;
    int lat;
    @(negedge clk);
    drive(0, 2'b10, 32'h30, 32'h1122_3344, 3'b010);
    @(negedge clk);
    rst = 1'b1;
    a_op = 2'b00;
    seen = 1'b0;
    @(negedge clk);
    seen = seen | a_ready;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | a_ready;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_wait_ready: got pulse %b expected 0", seen);
    end
    txn("rst_wait_lw30", 0, 2'b01, 32'h30, 32'h0, 3'b010);

    @(negedge clk);
    drive(0, 2'b10, 32'h34, 32'h5566_7788, 3'b010);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (a_ready) begin lat = n; break; end
    end
    n_checks++;
    if (lat !== 3) begin
      n_errors++;
      $display("FAIL rst_resp_latency: got %0d expected 3", lat);
    end
    rst = 1'b1;
    a_op = 2'b00;
    #1;
    n_checks++;
    if (a_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_resp_ready: got %b expected 0", a_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (a_rdata !== 32'h0) begin
      n_errors++;
      $display("FAIL rst_resp_rdata: got %h expected 0", a_rdata);
    end
    txn("rst_resp_lw34", 0, 2'b01, 32'h34, 32'h0, 3'b010);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [1:0] op;
    for (int i = 0; i < 40; i++) begin
      op   = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      addr = $urandom;
      txn("rand", 0, op, addr, $urandom, 3'($urandom_range(0, 7)));
    end
  endtask

  // WAIT_CYCLES=0: mem_op held as read; during each RESP a stray write is offered and must be ignored
  task automatic test_back_to_back();
    logic [31:0] addr, exp;
    logic [2:0] f3;
    @(negedge clk);
    addr = 32'($urandom_range(0, 63));
    f3 = 3'($urandom_range(0, 7));
    exp_q.push_back(model_read(1, addr, f3));
    drive(1, 2'b01, addr, 32'h0, f3);
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      n_checks++;
      if (b_ready !== n[0]) begin
        n_errors++;
        $display("FAIL b2b_ready cycle %0d: got %b expected %b", n, b_ready, n[0]);
      end
      if (n[0]) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (b_rdata !== exp) begin
          n_errors++;
          $display("FAIL b2b_rdata cycle %0d: got %h expected %h", n, b_rdata, exp);
        end
        if (n < 11) drive(1, 2'b10, 32'h08, 32'hA5A5_A5A5, 3'b010);
        else        drive(1, 2'b00, 32'h0, 32'h0, 3'b000);
      end else begin
        addr = 32'($urandom_range(0, 63));
        f3 = 3'($urandom_range(0, 7));
        exp_q.push_back(model_read(1, addr, f3));
        drive(1, 2'b01, addr, 32'h0, f3);
      end
    end
    @(negedge clk);
    n_checks++;
    if (b_ready !== 1'b0 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL b2b_drain: got ready %b pending %0d expected 0/0", b_ready, exp_q.size());
    end
    txn("b2b_stray_lw08", 1, 2'b01, 32'h08, 32'h0, 3'b010);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 2'b00, 32'h0, 32'h0, 3'b000);
    drive(1, 2'b00, 32'h0, 32'h0, 3'b000);
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_fill();
    test_sized();
    test_misalign();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
